// File: rtl/matrix_stream_transpose.sv
// Tiled matrix transpose: buffers a full matrix of input tiles, then streams out transposed tiles.
// Latency: first output tile valid the cycle after the last input handshake; output held while stalled.
// Define MATRIX_TRANSPOSE_PING_PONG_EN for two banks so filling and draining overlap.
module matrix_stream_transpose #(
    parameter int DATA_WIDTH   = 8,
    parameter int TOTAL_DIM0   = 4,
    parameter int TOTAL_DIM1   = 4,
    parameter int COMPUTE_DIM0 = 2,
    parameter int COMPUTE_DIM1 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [COMPUTE_DIM0*COMPUTE_DIM1],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [COMPUTE_DIM0*COMPUTE_DIM1],
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last
);
    localparam int NT0 = TOTAL_DIM0 / COMPUTE_DIM0;
    localparam int NT1 = TOTAL_DIM1 / COMPUTE_DIM1;
    localparam int TW0 = (NT0 > 1) ? $clog2(NT0) : 1;
    localparam int TW1 = (NT1 > 1) ? $clog2(NT1) : 1;
`ifdef MATRIX_TRANSPOSE_PING_PONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    generate
        if (TOTAL_DIM0 % COMPUTE_DIM0 != 0) begin : g_chk_dim0
            $error("COMPUTE_DIM0 must divide TOTAL_DIM0");
        end
        if (TOTAL_DIM1 % COMPUTE_DIM1 != 0) begin : g_chk_dim1
            $error("COMPUTE_DIM1 must divide TOTAL_DIM1");
        end
    endgenerate

    logic [TW1-1:0] in_tr_q, in_tr_d, out_tr_q, out_tr_d;
    logic [TW0-1:0] in_tc_q, in_tc_d, out_tc_q, out_tc_d;
    logic in_fire, out_fire, in_end, out_end;
    logic wr_bank, rd_bank;
    logic [DATA_WIDTH-1:0] mem_q [NB][TOTAL_DIM1][TOTAL_DIM0];

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;
    assign in_end   = (in_tr_q == TW1'(NT1-1)) && (in_tc_q == TW0'(NT0-1));
    assign out_end  = (out_tr_q == TW1'(NT1-1)) && (out_tc_q == TW0'(NT0-1));

    // Input walks tiles row-major (tc inner); output walks column-major (tr inner).
    always_comb begin
        in_tr_d  = in_tr_q;
        in_tc_d  = in_tc_q;
        out_tr_d = out_tr_q;
        out_tc_d = out_tc_q;
        if (in_fire) begin
            if (in_tc_q == TW0'(NT0-1)) begin
                in_tc_d = '0;
                in_tr_d = (in_tr_q == TW1'(NT1-1)) ? '0 : in_tr_q + 1'b1;
            end else begin
                in_tc_d = in_tc_q + 1'b1;
            end
        end
        if (out_fire) begin
            if (out_tr_q == TW1'(NT1-1)) begin
                out_tr_d = '0;
                out_tc_d = (out_tc_q == TW0'(NT0-1)) ? '0 : out_tc_q + 1'b1;
            end else begin
                out_tr_d = out_tr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_tr_q  <= '0;
            in_tc_q  <= '0;
            out_tr_q <= '0;
            out_tc_q <= '0;
        end else begin
            in_tr_q  <= in_tr_d;
            in_tc_q  <= in_tc_d;
            out_tr_q <= out_tr_d;
            out_tc_q <= out_tc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int r = 0; r < TOTAL_DIM1; r++) begin
                for (int c = 0; c < TOTAL_DIM0; c++) begin
                    if (TW1'(r / COMPUTE_DIM1) == in_tr_q && TW0'(c / COMPUTE_DIM0) == in_tc_q)
                        mem_q[wr_bank][r][c] <= data_in[(r % COMPUTE_DIM1)*COMPUTE_DIM0 + (c % COMPUTE_DIM0)];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < COMPUTE_DIM0*COMPUTE_DIM1; k++) data_out[k] = '0;
        for (int r = 0; r < TOTAL_DIM1; r++) begin
            for (int c = 0; c < TOTAL_DIM0; c++) begin
                if (TW1'(r / COMPUTE_DIM1) == out_tr_q && TW0'(c / COMPUTE_DIM0) == out_tc_q)
                    data_out[(c % COMPUTE_DIM0)*COMPUTE_DIM1 + (r % COMPUTE_DIM1)] = mem_q[rd_bank][r][c];
            end
        end
    end

`ifdef MATRIX_TRANSPOSE_PING_PONG_EN
    logic [1:0] full_q, full_d;
    logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // Fill and drain always target different banks, so both updates can land together.
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (in_fire && in_end) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (out_fire && out_end) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_bank        = wr_ptr_q;
    assign rd_bank        = rd_ptr_q;
    assign data_in_ready  = ~full_q[wr_ptr_q];
    assign data_out_valid = full_q[rd_ptr_q];
    assign data_out_last  = full_q[rd_ptr_q] & out_end;
`else
    typedef enum logic {FILL, DRAIN} state_e;
    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_fire && in_end)   state_d = DRAIN;
            DRAIN:   if (out_fire && out_end) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        data_in_ready  = (state_q == FILL);
        data_out_valid = (state_q == DRAIN);
        data_out_last  = (state_q == DRAIN) && out_end;
    end

    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_stream_transpose.sv
// Bench for matrix_stream_transpose: randomized matrices, scoreboard fed by a matrix-level model.
// A 4x4/2x2 instance carries most checks; a 2x6/1x2 instance covers the non-square shape.
module tb_matrix_stream_transpose;
    localparam int NE = 4, NT0 = 2, NT1 = 2, N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] din [NE];
    logic [7:0] dout [NE];
    logic din_vld = 1'b0, din_rdy, dout_vld, dout_last;
    logic dout_rdy = 1'b1;

    logic [7:0] d2_in [2];
    logic [7:0] d2_out [2];
    logic d2_ivld = 1'b0, d2_irdy, d2_ovld, d2_last;

    matrix_stream_transpose u_dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(din_vld), .data_in_ready(din_rdy),
        .data_out(dout), .data_out_valid(dout_vld), .data_out_ready(dout_rdy),
        .data_out_last(dout_last)
    );

    matrix_stream_transpose #(.DATA_WIDTH(8), .TOTAL_DIM0(6), .TOTAL_DIM1(2),
                              .COMPUTE_DIM0(2), .COMPUTE_DIM1(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .data_in(d2_in), .data_in_valid(d2_ivld), .data_in_ready(d2_irdy),
        .data_out(d2_out), .data_out_valid(d2_ovld), .data_out_ready(dout_rdy),
        .data_out_last(d2_last)
    );

    typedef struct { logic [31:0] d; logic last; } exp_t;
    exp_t q[$];
    exp_t q2[$];
    int tests = 0, fails = 0;
    int cyc = 0, stall_cycles = 0;
    int ordy_mode = 0, ordy_cnt = 0;

    always @(posedge clk) cyc++;

    // Output ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
    always @(posedge clk) begin
        #1;
        ordy_cnt++;
        case (ordy_mode)
            1:       dout_rdy = (ordy_cnt % 4 == 0) || (ordy_cnt % 4 == 3);
            2:       dout_rdy = 1'($urandom_range(0, 1));
            default: dout_rdy = 1'b1;
        endcase
    end

    logic [31:0] cur, prev_d;
    logic prev_last;
    logic stalled = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            for (int k = 0; k < NE; k++) cur[k*8 +: 8] = dout[k];
            if (stalled) begin
                tests++;
                if (!dout_vld || cur !== prev_d || dout_last !== prev_last) begin
                    fails++;
                    $display("FAIL hold: got vld=%0b d=%h last=%0b, need vld=1 d=%h last=%0b",
                             dout_vld, cur, dout_last, prev_d, prev_last);
                end
            end
`ifndef MATRIX_TRANSPOSE_PING_PONG_EN
            tests++;
            if (din_rdy !== !dout_vld) begin
                fails++;
                $display("FAIL rdy_vld_excl: in_ready=%0b out_valid=%0b", din_rdy, dout_vld);
            end
`endif
            if (dout_vld && dout_rdy) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got d=%h last=%0b, need no output", cur, dout_last);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.d || dout_last !== e.last) begin
                        fails++;
                        $display("FAIL out_tile: got d=%h last=%0b, need d=%h last=%0b",
                                 cur, dout_last, e.d, e.last);
                    end
                end
            end
            stalled   = dout_vld && !dout_rdy;
            prev_d    = cur;
            prev_last = dout_last;
        end
    end

    exp_t e2;
    logic [31:0] cur2;
    always @(negedge clk) begin
        if (!rst && d2_ovld && dout_rdy) begin
            cur2 = {16'h0, d2_out[1], d2_out[0]};
            tests++;
            if (q2.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out2: got d=%h", cur2);
            end else begin
                e2 = q2.pop_front();
                if (cur2 !== e2.d || d2_last !== e2.last) begin
                    fails++;
                    $display("FAIL out_tile2: got d=%h last=%0b, need d=%h last=%0b",
                             cur2, d2_last, e2.d, e2.last);
                end
            end
        end
    end

    task automatic send_tile(input logic [31:0] t, input bit bubbles);
        int n;
        bit hs;
        if (bubbles) begin
            while ($urandom_range(0, 1) == 1) begin
                din_vld = 1'b0;
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < NE; k++) din[k] = t[k*8 +: 8];
        din_vld = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs) begin
            @(negedge clk);
            hs = din_rdy;
            @(posedge clk); #1;
            n++;
            if (n > 300) begin
                tests++; fails++;
                $display("FAIL in_handshake_timeout: got no ready in %0d cycles, need ready", n);
                break;
            end
        end
        stall_cycles += n - 1;
        din_vld = 1'b0;
    endtask

    // Matrix-level model: expected output tiles are read straight out of M in transposed tile order.
    task automatic send_matrix(input bit rnd, input int base, input bit bubbles, input int ntiles);
        int M [4][4];
        exp_t x;
        logic [31:0] t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                M[r][c] = rnd ? int'($urandom_range(0, 255)) : base + r*4 + c;
        if (ntiles == N) begin
            for (int tc = 0; tc < NT0; tc++)
                for (int tr = 0; tr < NT1; tr++) begin
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++)
                            x.d[(j*2+i)*8 +: 8] = 8'(M[tr*2+i][tc*2+j]);
                    x.last = (tc == NT0-1) && (tr == NT1-1);
                    q.push_back(x);
                end
        end
        for (int k = 0; k < ntiles; k++) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    t[(i*2+j)*8 +: 8] = 8'(M[(k/NT0)*2+i][(k%NT0)*2+j]);
            send_tile(t, bubbles);
        end
`ifndef MATRIX_TRANSPOSE_PING_PONG_EN
        if (ntiles == N) begin
            tests++;
            if (dout_vld !== 1'b1) begin
                fails++;
                $display("FAIL latency: got out_valid=%0b after last input, need 1", dout_vld);
            end
        end
`endif
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d/%0d tiles left, need 0", q.size(), q2.size());
        end
        @(posedge clk); #1;
    endtask

    // Hold value 99 on a valid input while draining; it must never be accepted.
    task automatic drain_99();
`ifndef MATRIX_TRANSPOSE_PING_PONG_EN
        for (int k = 0; k < NE; k++) din[k] = 8'd99;
        din_vld = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!dout_vld) break;
            tests++;
            if (din_rdy !== 1'b0) begin
                fails++;
                $display("FAIL drain_ready: got in_ready=%0b during drain, need 0", din_rdy);
            end
            if (dout_rdy && dout_last) break;
        end
        din_vld = 1'b0;
`endif
    endtask

    task automatic send_matrix2();
        int M [2][6];
        exp_t x;
        int n;
        bit hs;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 6; c++) M[r][c] = int'($urandom_range(0, 255));
        for (int tc = 0; tc < 3; tc++)
            for (int tr = 0; tr < 2; tr++) begin
                x.d    = {16'h0, 8'(M[tr][tc*2+1]), 8'(M[tr][tc*2])};
                x.last = (tc == 2) && (tr == 1);
                q2.push_back(x);
            end
        for (int tr = 0; tr < 2; tr++)
            for (int tc = 0; tc < 3; tc++) begin
                d2_in[0] = 8'(M[tr][tc*2]);
                d2_in[1] = 8'(M[tr][tc*2+1]);
                d2_ivld  = 1'b1;
                hs = 1'b0;
                n  = 0;
                while (!hs && n < 300) begin
                    @(negedge clk);
                    hs = d2_irdy;
                    @(posedge clk); #1;
                    n++;
                end
                if (!hs) begin
                    tests++; fails++;
                    $display("FAIL in_handshake_timeout2: got no ready, need ready");
                end
                d2_ivld = 1'b0;
            end
    endtask

    initial begin
        int t0;
        for (int k = 0; k < NE; k++) din[k] = '0;
        d2_in[0] = '0;
        d2_in[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests += 3;
        if (din_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b, need 1", din_rdy); end
        if (dout_vld !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b, need 0", dout_vld); end
        if (dout_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %0b, need 0", dout_last); end
        @(posedge clk); #1;

        ordy_mode = 0;
        send_matrix(1'b0, 0, 1'b0, N);
        wait_empty(200);

        ordy_mode = 1;
        send_matrix(1'b0, 0, 1'b0, N);
        wait_empty(200);

        ordy_mode = 0;
        send_matrix(1'b0, 0, 1'b1, N);
        drain_99();
        wait_empty(200);

        send_matrix(1'b1, 0, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_matrix(1'b0, 100, 1'b0, N);
        wait_empty(200);

        ordy_mode = 2;
        for (int m = 0; m < 6; m++) begin
            send_matrix(1'b1, 0, 1'($urandom_range(0, 1)), N);
            drain_99();
            wait_empty(300);
        end

        ordy_mode = 0;
        send_matrix2();
        wait_empty(200);
        ordy_mode = 2;
        send_matrix2();
        wait_empty(300);

`ifdef MATRIX_TRANSPOSE_PING_PONG_EN
        ordy_mode    = 0;
        stall_cycles = 0;
        t0 = cyc;
        for (int m = 0; m < 3; m++) send_matrix(1'b1, 0, 1'b0, N);
        tests++;
        if (stall_cycles != 0) begin
            fails++;
            $display("FAIL pp_no_stall: got %0d input stall cycles, need 0", stall_cycles);
        end
        wait_empty(200);
        tests++;
        if (cyc - t0 > 4*N + 3) begin
            fails++;
            $display("FAIL pp_throughput: got %0d cycles for 3 matrices, need <= %0d", cyc - t0, 4*N + 3);
        end
`else
        t0 = cyc;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish by %0t, need completion", $time);
        $fatal(1, "timeout");
    end
endmodule
